id_ex_alu_feed: RTL

//  ID/EX pipeline stage directly upstream of the ALU: registers decoded operands and controls,

---
 rtl/id_ex_alu_feed_pkg.sv | 26 ++
 rtl/id_ex_alu_feed_alu_ctrl_decode.sv | 24 ++
 rtl/id_ex_alu_feed.sv | 112 +++++++++++
 3 files changed

// File: rtl/id_ex_alu_feed_pkg.sv
// id_ex_alu_feed_pkg: shared ALU control codes, alu_op encodings and R-type funct values
package id_ex_alu_feed_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_NOT  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_NOT = 6'h27;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
endpackage

// File: rtl/id_ex_alu_feed_alu_ctrl_decode.sv
// alu_ctrl_decode: combinational alu_op/funct to 4-bit ALU control code
// Ports: alu_op (2) and funct (6) in; alu_cnt (4) out, ALU_NONE for unknown R-type funct.
module alu_ctrl_decode
  import id_ex_alu_feed_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_cnt
);
  logic [3:0] w_rtype;
  always_comb begin
    w_rtype = funct == F_ADD ? ALU_ADD :
              funct == F_SUB ? ALU_SUB :
              funct == F_NOT ? ALU_NOT :
              funct == F_SLL ? ALU_SLL :
              funct == F_SRL ? ALU_SRL :
              funct == F_AND ? ALU_AND :
              funct == F_OR  ? ALU_OR  :
              funct == F_SLT ? ALU_SLT : ALU_NONE;
    alu_cnt = alu_op == OP_ADD ? ALU_ADD :
              alu_op == OP_SUB ? ALU_SUB :
              alu_op == OP_OR  ? ALU_OR  : w_rtype;
  end
endmodule

// File: rtl/id_ex_alu_feed.sv
// id_ex_alu_feed: ID/EX register stage with ALU control decode and EX/MEM, MEM/WB operand forwarding
// Ports: clk/rst (sync, active-high); stall holds, flush inserts a bubble (flush wins);
//   id_* decoded instruction in; exm_*/mwb_* later-stage writeback info for forwarding;
//   ex_valid, alu_cnt, alu_in1/alu_in2, alu_shamt, ex_store_data, ex_rd, ex_* controls out.
module id_ex_alu_feed
  import id_ex_alu_feed_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [3:0]        alu_cnt,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);
  logic [3:0]        w_cnt;
  logic              w_bubble;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic              r_valid;
  logic [3:0]        r_cnt;
  logic [3:0]        r_ctrl;
  logic              r_alu_src;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_val;
  logic [DATA_W-1:0] r_rt_val;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;
  alu_ctrl_decode u_dec (
    .alu_op (id_alu_op),
    .funct  (id_funct),
    .alu_cnt(w_cnt)
  );
  assign w_bubble = flush | ~id_valid;
  // Data fields load even on a bubble; only valid, controls and alu_cnt must be cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_cnt     <= ALU_ADD;
      r_ctrl    <= '0;
      r_alu_src <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_rs_val  <= '0;
      r_rt_val  <= '0;
      r_imm     <= '0;
      r_shamt   <= '0;
    end else if (flush | ~stall) begin
      r_valid   <= ~w_bubble;
      r_cnt     <= w_bubble ? ALU_ADD : w_cnt;
      r_ctrl    <= w_bubble ? 4'b0000 : {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg};
      r_alu_src <= id_alu_src;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_rs_val  <= id_rs_val;
      r_rt_val  <= id_rt_val;
      r_imm     <= id_imm;
      r_shamt   <= id_shamt;
    end
  end
  // Youngest producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_rs = exm_reg_write && exm_rd != '0 && exm_rd == r_rs ? exm_result :
               mwb_reg_write && mwb_rd != '0 && mwb_rd == r_rs ? mwb_result : r_rs_val;
    w_fwd_rt = exm_reg_write && exm_rd != '0 && exm_rd == r_rt ? exm_result :
               mwb_reg_write && mwb_rd != '0 && mwb_rd == r_rt ? mwb_result : r_rt_val;
  end
  assign ex_valid      = r_valid;
  assign alu_cnt       = r_cnt;
  assign alu_in1       = w_fwd_rs;
  assign alu_in2       = r_alu_src ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_shamt     = r_shamt;
  assign ex_rd         = r_rd;
  assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = r_ctrl;
endmodule
